instr_mem_bank: RTL and testbench
=================================

INSTR_MEM_BANK -- requirements
Module: instr_mem_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning storage element (byte) width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, meaning byte address width.
REQ-003 The block SHALL have parameter WORD_BYTES, default 4, meaning bytes per returned word; rdata width = WORD_BYTES*DATA_WIDTH.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, range 0..15, meaning extra read cycles.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic on the rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-007 The block SHALL have port req, input, 1, meaning read request.
REQ-008 The block SHALL have port addr, input, ADDR_WIDTH, meaning read byte address.
REQ-009 The block SHALL have port ready, output, 1, meaning a request is accepted this cycle.
REQ-010 The block SHALL have port rvalid, output, 1, meaning rdata/err valid this cycle.
REQ-011 The block SHALL have port rdata, output, WORD_BYTES*DATA_WIDTH, meaning the read word.
REQ-012 The block SHALL have port err, output, 1, meaning the misaligned-request flag.
REQ-013 The block SHALL have ports ld_we (input, 1), ld_addr (input, ADDR_WIDTH) and ld_data (input, DATA_WIDTH), meaning a byte-wide program-load write port.

Function
REQ-014 Storage SHALL be 2^ADDR_WIDTH bytes, zero at time zero.
REQ-015 Words SHALL be big-endian: byte at addr occupies the rdata MSBs; byte addr+WORD_BYTES-1 occupies the LSBs.
REQ-016 Byte addresses addr+k SHALL wrap modulo 2^ADDR_WIDTH.
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; ready = 1 only in IDLE.
REQ-018 In IDLE, req=1 SHALL latch addr and go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0); req=0 SHALL stay in IDLE.
REQ-019 WAIT SHALL count WAIT_STATES cycles, then go to RESP.
REQ-020 Entering RESP SHALL register rdata from the latched address; rvalid = 1 for exactly one cycle, then return to IDLE.
REQ-021 Latency from the accept edge to rvalid SHALL be 1+WAIT_STATES cycles; back-to-back accepts SHALL be spaced 2+WAIT_STATES cycles apart.
REQ-022 rdata and err SHALL hold their last values outside RESP.
REQ-023 ld_we=1 SHALL write ld_data to ld_addr at the clock edge, in any state.
REQ-024 A write on the same edge that captures rdata SHALL not be visible in that rdata (read-before-write).
REQ-025 A write during WAIT to a pending byte SHALL be visible in the response.
REQ-026 req while ready=0 SHALL be ignored, not queued.

Reset
REQ-027 rst SHALL force IDLE, counter=0, rvalid=0, err=0 and rdata=0, with ready=1 after release.
REQ-028 rst SHALL not alter storage contents.
REQ-029 rst asserted in WAIT or RESP SHALL abort the response with no rvalid pulse.

Configuration
REQ-030 With macro IMEM_MISALIGN_CHK_EN defined, a request with addr mod WORD_BYTES != 0 SHALL respond with err=1 and rdata=0 at normal latency.
REQ-031 Without IMEM_MISALIGN_CHK_EN, err SHALL be tied 0 and a misaligned read SHALL assemble bytes addr..addr+WORD_BYTES-1 with wrap.

Structure
REQ-032 A shared package imem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP) and the default parameter constants.
REQ-033 The byte array with its load-write port SHALL be one sub-module, imem_byte_array; the FSM, counter and word assembly SHALL be in instr_mem_bank.

Verification
REQ-034 Load 0x08,0x00,0x00,0x05 at addresses 0..3, WAIT_STATES=0, req addr=0 -> rvalid the next cycle, rdata=0x08000005, err=0.
REQ-035 WAIT_STATES=3, req addr=4 -> rvalid 4 cycles after accept; ready=0 throughout; a second req during WAIT gets no response.
REQ-036 Addr=62 (ADDR_WIDTH=6) with bytes 62,63,0,1 = AA,BB,CC,DD: without the macro -> rdata=0xAABBCCDD, err=0; with the macro -> rdata=0, err=1.
REQ-037 WAIT_STATES=2: ld_we to pending byte addr+1=0x11 during WAIT -> response includes 0x11; a write on the RESP capture edge -> old byte returned.
REQ-038 rst pulsed 1 cycle into WAIT -> no rvalid, rdata=0, ready=1 after release; a re-read returns the pre-reset contents.

Source files
------------

// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared FSM state encoding and default parameters for the
//               instruction memory bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int c_DATA_WIDTH  = 8;
    localparam int c_ADDR_WIDTH  = 6;
    localparam int c_WORD_BYTES  = 4;
    localparam int c_WAIT_STATES = 0;
    localparam int c_CNT_WIDTH   = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/imem_byte_array.sv
// ============================================================================
// Module      : imem_byte_array
// Description : Byte-wide storage with a program-load write port and
//               WORD_BYTES asynchronous read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_byte_array
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int WORD_BYTES = c_WORD_BYTES
) (
    input  logic                             clk,
    input  logic                             ld_we,
    input  logic [ADDR_WIDTH-1:0]            ld_addr,
    input  logic [DATA_WIDTH-1:0]            ld_data,
    input  logic [WORD_BYTES*ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // No reset: program contents must survive a reset of the bank.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    generate
        for (genvar k = 0; k < WORD_BYTES; k++) begin : g_rd_port
            assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/instr_mem_bank.sv
// ============================================================================
// Module      : instr_mem_bank
// Description : Wait-state instruction memory returning big-endian words.
//               Optional macro IMEM_MISALIGN_CHK_EN flags misaligned reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_bank
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH,
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int WORD_BYTES  = c_WORD_BYTES,
    parameter int WAIT_STATES = c_WAIT_STATES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req,
    input  logic [ADDR_WIDTH-1:0]            addr,
    output logic                             ready,
    output logic                             rvalid,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] rdata,
    output logic                             err,
    input  logic                             ld_we,
    input  logic [ADDR_WIDTH-1:0]            ld_addr,
    input  logic [DATA_WIDTH-1:0]            ld_data
);

    localparam int c_RDW = WORD_BYTES * DATA_WIDTH;
    localparam logic [c_CNT_WIDTH-1:0] c_LAST = c_CNT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_CNT_WIDTH-1:0]          r_cnt;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [ADDR_WIDTH-1:0]           w_base;
    logic                            w_capture;
    logic [WORD_BYTES*ADDR_WIDTH-1:0] w_rd_addr;
    logic [c_RDW-1:0]                w_rd_data;
    logic [c_RDW-1:0]                w_word;
    logic [c_RDW-1:0]                r_rdata;

    imem_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_array (
        .clk     (clk),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    // With zero wait states the capture happens on the accept edge itself.
    assign w_base = (r_state == IDLE) ? addr : r_addr;

    generate
        for (genvar k = 0; k < WORD_BYTES; k++) begin : g_word
            assign w_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = w_base + ADDR_WIDTH'(k);
            assign w_word[(WORD_BYTES-1-k)*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = RESP;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && req) begin
                r_addr <= addr;
            end
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

`ifdef IMEM_MISALIGN_CHK_EN
    logic w_misalign;
    logic r_err;

    assign w_misalign = (32'(w_base) % WORD_BYTES) != 0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_rdata <= w_misalign ? '0 : w_word;
            r_err   <= w_misalign;
        end
    end

    assign err = r_err;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata <= w_word;
        end
    end

    assign err = 1'b0;
`endif

    assign rdata  = r_rdata;
    assign ready  = (r_state == IDLE);
    assign rvalid = (r_state == RESP);

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_bank.sv
// ============================================================================
// Module      : tb_instr_mem_bank
// Description : Randomized scoreboard bench for instr_mem_bank (WAIT_STATES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_bank;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int WB = 4;
    localparam int WS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ready;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    typedef struct {
        logic [31:0] word;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  model [64];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] last_word = '0;
    logic        last_err = 1'b0;

    instr_mem_bank #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WORD_BYTES  (WB),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (addr),
        .ready   (ready),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .err     (err),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte k of the word comes from (a+k) mod 64, first byte most significant.
    function automatic exp_t model_resp(input logic [5:0] a, input int due);
        exp_t e;
        e.cyc  = due;
        e.err  = 1'b0;
        e.word = '0;
`ifdef IMEM_MISALIGN_CHK_EN
        if ((int'(a) % WB) != 0) begin
            e.err = 1'b1;
            return e;
        end
`endif
        for (int k = 0; k < WB; k++) begin
            e.word = (e.word << 8) | 32'(model[(int'(a) + k) % 64]);
        end
        return e;
    endfunction

    // Monitor: samples shortly after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (rst) begin
                sbq.delete();
                last_word = '0;
                last_err  = 1'b0;
                check("rvalid_in_reset", 32'(rvalid), 32'd0);
            end else if (rvalid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rdata", rdata, e.word);
                    check("err", 32'(err), 32'(e.err));
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                    last_word = e.word;
                    last_err  = e.err;
                end
            end else begin
                check("rdata_hold", rdata, last_word);
                check("err_hold", 32'(err), 32'(last_err));
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_load(input logic [5:0] a, input logic [7:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        model[a] = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // wj: edge offset from the accept edge at which a byte write lands (-1 = none).
    // The word is captured WS edges after acceptance, so only earlier writes show.
    task automatic do_read(input logic [5:0] a, input int wj, input logic [5:0] wa,
                           input logic [7:0] wd, input bit extra);
        exp_t e;
        wait_ready();
        if (wj >= 0 && wj < WS) model[wa] = wd;
        e = model_resp(a, cyc + 1 + WS);
        if (wj >= WS) model[wa] = wd;
        sbq.push_back(e);
        for (int j = 0; j <= WS + 1; j++) begin
            if (j > 0) check("ready_busy", 32'(ready), 32'd0);
            req     = (j == 0) || (extra && j == 1);
            addr    = (j == 0) ? a : 6'($urandom);
            ld_we   = (j == wj);
            ld_addr = wa;
            ld_data = wd;
            @(negedge clk);
        end
        req   = 1'b0;
        ld_we = 1'b0;
        check("ready_idle", 32'(ready), 32'd1);
    endtask

    task automatic do_reset_abort(input logic [5:0] a);
        wait_ready();
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_rdata", rdata, 32'd0);
        check("abort_err", 32'(err), 32'd0);
        repeat (WS + 3) @(negedge clk);
        do_read(a, -1, 6'd0, 8'd0, 1'b0);
    endtask

    initial begin
        logic [5:0] a;
        logic [5:0] wa;
        int         wj;
        for (int i = 0; i < 64; i++) model[i] = 8'h00;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);

        do_read(6'd0, -1, 6'd0, 8'd0, 1'b0);

        do_load(6'd0, 8'h08); do_load(6'd1, 8'h00); do_load(6'd2, 8'h00); do_load(6'd3, 8'h05);
        do_read(6'd0, -1, 6'd0, 8'd0, 1'b0);

        do_load(6'd62, 8'hAA); do_load(6'd63, 8'hBB); do_load(6'd0, 8'hCC); do_load(6'd1, 8'hDD);
        do_read(6'd62, -1, 6'd0, 8'd0, 1'b0);

        do_read(6'd4, 1, 6'd5, 8'h11, 1'b0);
        do_read(6'd8, WS, 6'd9, 8'h22, 1'b0);
        do_read(6'd8, -1, 6'd0, 8'd0, 1'b0);
        do_read(6'd4, -1, 6'd0, 8'd0, 1'b1);

        do_reset_abort(6'd4);

        for (int i = 0; i < 40; i++) do_load(6'($urandom), 8'($urandom));

        for (int i = 0; i < 120; i++) begin
            a  = 6'($urandom);
            wj = int'($urandom_range(0, WS + 2)) - 1;
            wa = ($urandom_range(0, 1) == 1) ? a + 6'($urandom_range(0, WB - 1)) : 6'($urandom);
            do_read(a, wj, wa, 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(6'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (WS + 4) @(negedge clk);
        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
